traffic_light_controller: RTL and testbench



---
 rtl/traffic_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/traffic_light_controller.sv | 143 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    WALK        = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4
  } state_t;

  // Lamp encodings, {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // An N-second interval ends on the tick that completes second N-1.
  function automatic logic interval_done(input logic tick, input logic [3:0] sec,
                                         input logic [3:0] limit);
    return tick && (sec == limit - 4'd1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Free-running count, restarted by reset, by a state change, or after the last cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Moore sequencer for main/side street lights and the pedestrian walk lamp.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int T_MAIN_MIN = 6,
  parameter int T_SIDE     = 6,
  parameter int T_EXT      = 3,
  parameter int T_YEL      = 2,
  parameter int T_WALK     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pending_walk,
  input  logic       side_sensor,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic       walk_clear,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] MAIN_MIN = 4'(T_MAIN_MIN);
  localparam logic [3:0] SIDE_LIM = 4'(T_SIDE);
  localparam logic [3:0] EXT_LIM  = 4'(T_EXT);
  localparam logic [3:0] YEL_LIM  = 4'(T_YEL);
  localparam logic [3:0] WALK_LIM = 4'(T_WALK);

  state_t     state, next_state;
  logic [3:0] sec;
  logic       ext_used;
  logic       ext_now;
  logic       restart;
  logic       tick;
  logic [2:0] main_d, side_d;
  logic       walk_lamp_d, walk_clear_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(restart),
    .tick (tick)
  );

  assign state_dbg = state;

  // Next-state selection; an extension restarts the timer without leaving SIDE_GREEN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = state;
    ext_now    = 1'b0;
    case (state)
      MAIN_GREEN: begin
        // The minimum is met either once sec has reached it or on the tick that completes it.
        if ((sec >= MAIN_MIN || interval_done(tick, sec, MAIN_MIN)) &&
            (side_sensor || pending_walk)) begin
          next_state = MAIN_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (interval_done(tick, sec, YEL_LIM)) begin
          next_state = pending_walk ? WALK : SIDE_GREEN;
        end
      end
      WALK: begin
        if (interval_done(tick, sec, WALK_LIM)) begin
          next_state = side_sensor ? SIDE_GREEN : MAIN_GREEN;
        end
      end
      SIDE_GREEN: begin
        if (interval_done(tick, sec, ext_used ? EXT_LIM : SIDE_LIM)) begin
          if (side_sensor && !ext_used) begin
            ext_now = 1'b1;
          end else begin
            next_state = SIDE_YELLOW;
          end
        end
      end
      SIDE_YELLOW: begin
        if (interval_done(tick, sec, YEL_LIM)) begin
          next_state = MAIN_GREEN;
        end
      end
      default: next_state = MAIN_GREEN;
    endcase
    restart = (next_state != state) || ext_now;
  end

  // Output decode from the next state so the lamps change on the same edge as the state.
  always_comb begin
    main_d       = GRN;
    side_d       = RED;
    walk_lamp_d  = 1'b0;
    walk_clear_d = 1'b0;
    case (next_state)
      MAIN_YELLOW: main_d = YEL;
      WALK: begin
        main_d       = RED;
        walk_lamp_d  = 1'b1;
        walk_clear_d = (state != WALK);
      end
      SIDE_GREEN: begin
        main_d = RED;
        side_d = GRN;
      end
      SIDE_YELLOW: begin
        main_d = RED;
        side_d = YEL;
      end
      default: ;
    endcase
  end

  // State, seconds counter, extension flag and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= MAIN_GREEN;
      sec         <= '0;
      ext_used    <= 1'b0;
      main_lights <= GRN;
      side_lights <= RED;
      walk_lamp   <= 1'b0;
      walk_clear  <= 1'b0;
    end else begin
      state       <= next_state;
      main_lights <= main_d;
      side_lights <= side_d;
      walk_lamp   <= walk_lamp_d;
      walk_clear  <= walk_clear_d;
      if (restart) begin
        sec <= '0;
      end else if (tick && sec != 4'd15) begin
        sec <= sec + 4'd1;
      end
      if (ext_now) begin
        ext_used <= 1'b1;
      end else if (next_state == MAIN_GREEN && state != MAIN_GREEN) begin
        ext_used <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scenario-table bench: each scenario lists its input windows and the cycles at
// which the controller must enter each state; every cycle is checked.
module tb_traffic_light_controller;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pending_walk;
  logic       side_sensor;
  logic [2:0] main_lights, side_lights, state_dbg;
  logic       walk_lamp, walk_clear;

  int n_checks = 0;
  int n_errors = 0;

  traffic_light_controller #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pending_walk(pending_walk),
    .side_sensor (side_sensor),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk_lamp   (walk_lamp),
    .walk_clear  (walk_clear),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Sensor is high on cycles [s1_from..s1_to] and [s2_from..s2_to]; walk push on push_at;
  // reset held low on cycle 0 and on reset_at. Cycle k means "after posedge k".
  typedef struct {
    string name;
    int    cycles;
    int    s1_from, s1_to, s2_from, s2_to;
    int    push_at;
    int    reset_at;
  } scen_t;

  typedef struct {
    int     scen;
    int     start;
    state_t st;
  } seg_t;

  typedef struct {
    int          cycle;
    logic [10:0] bits;
  } exp_t;

  scen_t scens[$];
  seg_t  segs[$];
  exp_t  sb[$];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic state_t exp_state(input int s, input int k);
    state_t r = MAIN_GREEN;
    foreach (segs[i]) if (segs[i].scen == s && segs[i].start <= k) r = segs[i].st;
    return r;
  endfunction

  function automatic logic walk_entry(input int s, input int k);
    foreach (segs[i]) if (segs[i].scen == s && segs[i].st == WALK && segs[i].start == k) return 1'b1;
    return 1'b0;
  endfunction

  // {main, side} lamp pattern required in each state.
  function automatic logic [5:0] lamps(input state_t st);
    case (st)
      MAIN_GREEN:  return {3'b001, 3'b100};
      MAIN_YELLOW: return {3'b010, 3'b100};
      WALK:        return {3'b100, 3'b100};
      SIDE_GREEN:  return {3'b100, 3'b001};
      SIDE_YELLOW: return {3'b100, 3'b010};
      default:     return 6'b0;
    endcase
  endfunction

  task automatic add_seg(input int s, input int start, input state_t st);
    seg_t g;
    g.scen = s; g.start = start; g.st = st;
    segs.push_back(g);
  endtask

  task automatic run_scen(input int s);
    scen_t sc = scens[s];
    logic  last_clear = 1'b0;
    for (int k = 0; k <= sc.cycles; k++) begin
      exp_t   e;
      state_t st;
      logic   conflict;
      reset       = !(k == 0 || k == sc.reset_at);
      side_sensor = (k >= sc.s1_from && k <= sc.s1_to) || (k >= sc.s2_from && k <= sc.s2_to);
      // External walk register: set by a push, cleared by the FSM's walk_clear.
      if (k == 0) pending_walk = 1'b0;
      else if (k == sc.push_at) pending_walk = 1'b1;
      else if (last_clear) pending_walk = 1'b0;
      st     = exp_state(s, k);
      e.cycle = k;
      e.bits  = {st, lamps(st), st == WALK, walk_entry(s, k)};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s cycle %0d {state,main,side,lamp,clear}", sc.name, e.cycle),
            {state_dbg, main_lights, side_lights, walk_lamp, walk_clear}, e.bits);
      conflict = (main_lights != 3'b100 && side_lights != 3'b100) ||
                 (walk_lamp && (main_lights != 3'b100 || side_lights != 3'b100));
      if (conflict) begin
        check($sformatf("%s cycle %0d safety", sc.name, e.cycle), 11'(conflict), 11'd0);
      end
      last_clear = walk_clear;
    end
  endtask

  initial begin
    reset        = 1'b0;
    pending_walk = 1'b0;
    side_sensor  = 1'b0;

    scens.push_back('{name:"idle",       cycles:200, s1_from:-1, s1_to:-1,   s2_from:-1, s2_to:-1,   push_at:-1,  reset_at:-1});
    add_seg(0, 0, MAIN_GREEN);

    scens.push_back('{name:"sensor",     cycles:150, s1_from:0,  s1_to:1000, s2_from:-1, s2_to:-1,   push_at:-1,  reset_at:-1});
    add_seg(1, 0, MAIN_GREEN);  add_seg(1, 24, MAIN_YELLOW); add_seg(1, 32, SIDE_GREEN);
    add_seg(1, 68, SIDE_YELLOW); add_seg(1, 76, MAIN_GREEN); add_seg(1, 100, MAIN_YELLOW);
    add_seg(1, 108, SIDE_GREEN); add_seg(1, 144, SIDE_YELLOW);

    scens.push_back('{name:"walk",       cycles:60,  s1_from:-1, s1_to:-1,   s2_from:-1, s2_to:-1,   push_at:5,   reset_at:-1});
    add_seg(2, 0, MAIN_GREEN); add_seg(2, 24, MAIN_YELLOW); add_seg(2, 32, WALK);
    add_seg(2, 44, MAIN_GREEN);

    scens.push_back('{name:"both",       cycles:90,  s1_from:20, s1_to:24,   s2_from:30, s2_to:1000, push_at:30,  reset_at:-1});
    add_seg(3, 0, MAIN_GREEN); add_seg(3, 24, MAIN_YELLOW); add_seg(3, 32, WALK);
    add_seg(3, 44, SIDE_GREEN); add_seg(3, 80, SIDE_YELLOW); add_seg(3, 88, MAIN_GREEN);

    scens.push_back('{name:"late_walk",  cycles:115, s1_from:0,  s1_to:32,   s2_from:-1, s2_to:-1,   push_at:40,  reset_at:-1});
    add_seg(4, 0, MAIN_GREEN); add_seg(4, 24, MAIN_YELLOW); add_seg(4, 32, SIDE_GREEN);
    add_seg(4, 56, SIDE_YELLOW); add_seg(4, 64, MAIN_GREEN); add_seg(4, 88, MAIN_YELLOW);
    add_seg(4, 96, WALK); add_seg(4, 108, MAIN_GREEN);

    scens.push_back('{name:"saturate",   cycles:125, s1_from:-1, s1_to:-1,   s2_from:-1, s2_to:-1,   push_at:100, reset_at:-1});
    add_seg(5, 0, MAIN_GREEN); add_seg(5, 100, MAIN_YELLOW); add_seg(5, 108, WALK);
    add_seg(5, 120, MAIN_GREEN);

    scens.push_back('{name:"mid_reset",  cycles:80,  s1_from:0,  s1_to:1000, s2_from:-1, s2_to:-1,   push_at:-1,  reset_at:40});
    add_seg(6, 0, MAIN_GREEN); add_seg(6, 24, MAIN_YELLOW); add_seg(6, 32, SIDE_GREEN);
    add_seg(6, 40, MAIN_GREEN); add_seg(6, 64, MAIN_YELLOW); add_seg(6, 72, SIDE_GREEN);

    foreach (scens[s]) run_scen(s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
